// File: rtl/motion_sequencer.sv
// motion_sequencer: queues timed direction commands and plays them out as the H-bridge motiondir code.
// Optional MOTION_SEQ_DEADTIME_EN builds the DEAD state (DEAD_TICKS of rest between differing nonzero directions).
module motion_sequencer #(
    parameter int TICK_DIV   = 100000,
    parameter int DUR_W      = 16,
    parameter int DEPTH      = 4,
    parameter int DEAD_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_dir,
    input  logic [DUR_W-1:0] cmd_dur,
    input  logic             abort,
    output logic [3:0]       motiondir,
    output logic             busy,
    output logic             done_pulse,
    output logic             err_pulse
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
`ifdef MOTION_SEQ_DEADTIME_EN
        ,
        DEAD = 2'd2
`endif
    } state_t;

    state_t state, next_state;

    logic [3:0]       fifo_dir [DEPTH];
    logic [DUR_W-1:0] fifo_dur [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, empty, push, pop;
    logic [3:0]       head_dir;
    logic [DUR_W-1:0] head_dur;

    logic [PW-1:0]    presc;
    logic [DUR_W-1:0] remain;
    logic [3:0]       cur_dir;
    logic             tick_wrap, last_cycle;
    logic             load_run, load_dead, done_d;
    logic [3:0]       motion_d;
    logic             busy_d;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready && (cmd_dir <= 4'd4) && !abort;
    assign head_dir  = fifo_dir[rd_ptr];
    assign head_dur  = fifo_dur[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dir[wr_ptr] <= cmd_dir;
            fifo_dur[wr_ptr] <= cmd_dur;
        end
    end

    // Abort empties the queue on the same edge that any concurrent push is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign tick_wrap  = (presc == PW'(TICK_DIV - 1));
    assign last_cycle = tick_wrap && (remain == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // On the last cycle of a segment, zero-duration heads are popped while holding the final count,
    // so the following cycle reports their completion and re-examines the queue.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load_run   = 1'b0;
        load_dead  = 1'b0;
        done_d     = 1'b0;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        pop = 1'b1;
                        if (head_dur == '0) begin
                            done_d = 1'b1;
                        end else begin
                            next_state = RUN;
                            load_run   = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_cycle) begin
                        done_d = 1'b1;
                        if (empty) begin
                            next_state = IDLE;
                        end else if (head_dur == '0) begin
                            pop = 1'b1;
`ifdef MOTION_SEQ_DEADTIME_EN
                        end else if (DEAD_TICKS != 0 && head_dir != cur_dir &&
                                     head_dir != 4'd0 && cur_dir != 4'd0) begin
                            next_state = DEAD;
                            load_dead  = 1'b1;
`endif
                        end else begin
                            pop      = 1'b1;
                            load_run = 1'b1;
                        end
                    end
                end
`ifdef MOTION_SEQ_DEADTIME_EN
                DEAD: begin
                    if (last_cycle) begin
                        pop        = 1'b1;
                        next_state = RUN;
                        load_run   = 1'b1;
                    end
                end
`endif
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            presc   <= '0;
            remain  <= '0;
            cur_dir <= 4'd0;
        end else if (load_run) begin
            presc   <= '0;
            remain  <= head_dur;
            cur_dir <= head_dir;
        end else if (load_dead) begin
            presc   <= '0;
            remain  <= DUR_W'(DEAD_TICKS);
        end else if (state != IDLE && !last_cycle) begin
            if (tick_wrap) begin
                presc  <= '0;
                remain <= remain - DUR_W'(1);
            end else begin
                presc  <= presc + PW'(1);
            end
        end
    end

    always_comb begin
        motion_d = 4'd0;
        if (state == RUN && !abort)
            motion_d = cur_dir;
        busy_d = !abort && ((state != IDLE) || !empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            motiondir  <= 4'd0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            motiondir  <= motion_d;
            busy       <= busy_d;
            done_pulse <= done_d;
            err_pulse  <= cmd_valid && cmd_ready && (cmd_dir > 4'd4);
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: directed scenarios for motion_sequencer with TICK_DIV=4, DEPTH=4, DEAD_TICKS=1.
module tb_motion_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_dir = 4'd0;
    logic [15:0] cmd_dur = 16'd0;
    logic        abort = 1'b0;
    logic [3:0]  motiondir;
    logic        busy, done_pulse, err_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] tr_dir   [0:127];
    logic       tr_done  [0:127];
    logic       tr_busy  [0:127];
    logic       tr_ready [0:127];
    logic [3:0] exp_dir  [0:127];
    int         idx;

    motion_sequencer #(
        .TICK_DIV  (4),
        .DUR_W     (16),
        .DEPTH     (4),
        .DEAD_TICKS(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_dur   (cmd_dur),
        .abort     (abort),
        .motiondir (motiondir),
        .busy      (busy),
        .done_pulse(done_pulse),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trace index k holds the outputs sampled just after the k-th edge of a scenario.
    task automatic tick_rec();
        tick();
        if (idx < 128) begin
            tr_dir[idx]   = motiondir;
            tr_done[idx]  = done_pulse;
            tr_busy[idx]  = busy;
            tr_ready[idx] = cmd_ready;
        end
        idx++;
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 128; k++) exp_dir[k] = 4'd0;
    endtask

    task automatic set_exp(input int lo, input int hi, input logic [3:0] v);
        for (int k = lo; k <= hi; k++) exp_dir[k] = v;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [15:0] t);
        cmd_valid = v;
        cmd_dir   = d;
        cmd_dur   = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if (motiondir !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset motiondir: got %0d expected 0", motiondir);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset busy: got %0b expected 0", busy);
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset cmd_ready: got %0b expected 1", cmd_ready);
        end
        tests_run++;
        if (done_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset pulses: got done=%0b err=%0b expected 0 0", done_pulse, err_pulse);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int dones;
        clear_exp();
        set_exp(2, 13, 4'd1);
        idx = 0;
        drive(1'b1, 4'd1, 16'd3);
        tick_rec();
        drive(1'b0, 4'd0, 16'd0);
        while (idx <= 17) tick_rec();
        for (int k = 0; k <= 17; k++) begin
            tests_run++;
            if (tr_dir[k] !== exp_dir[k]) begin
                tests_failed++;
                $display("[TB] FAIL single motiondir[%0d]: got %0d expected %0d", k, tr_dir[k], exp_dir[k]);
            end
        end
        dones = 0;
        for (int k = 0; k <= 17; k++) dones += int'(tr_done[k]);
        tests_run++;
        if (dones != 1 || tr_done[13] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single done: got count=%0d at13=%0b expected 1 1", dones, tr_done[13]);
        end
        tests_run++;
        if (tr_busy[1] !== 1'b1 || tr_busy[17] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single busy: got %0b/%0b expected 1/0", tr_busy[1], tr_busy[17]);
        end
    endtask

    task automatic test_dir_change();
        int dones;
        int last;
        clear_exp();
        set_exp(2, 9, 4'd1);
`ifdef MOTION_SEQ_DEADTIME_EN
        set_exp(14, 21, 4'd2);
`else
        set_exp(10, 17, 4'd2);
`endif
        last = 24;
        idx = 0;
        drive(1'b1, 4'd1, 16'd2);
        tick_rec();
        drive(1'b1, 4'd2, 16'd2);
        tick_rec();
        drive(1'b0, 4'd0, 16'd0);
        while (idx <= last) tick_rec();
        for (int k = 0; k <= last; k++) begin
            tests_run++;
            if (tr_dir[k] !== exp_dir[k]) begin
                tests_failed++;
                $display("[TB] FAIL dirchange motiondir[%0d]: got %0d expected %0d", k, tr_dir[k], exp_dir[k]);
            end
        end
        dones = 0;
        for (int k = 0; k <= last; k++) dones += int'(tr_done[k]);
        tests_run++;
        if (dones != 2) begin
            tests_failed++;
            $display("[TB] FAIL dirchange done count: got %0d expected 2", dones);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        clear_exp();
        set_exp(2, 9, 4'd3);
        idx = 0;
        drive(1'b1, 4'd3, 16'd1);
        tick_rec();
        tick_rec();
        drive(1'b0, 4'd0, 16'd0);
        while (idx <= 12) tick_rec();
        for (int k = 0; k <= 12; k++) begin
            tests_run++;
            if (tr_dir[k] !== exp_dir[k]) begin
                tests_failed++;
                $display("[TB] FAIL b2b motiondir[%0d]: got %0d expected %0d", k, tr_dir[k], exp_dir[k]);
            end
        end
        dones = 0;
        for (int k = 0; k <= 12; k++) dones += int'(tr_done[k]);
        tests_run++;
        if (dones != 2 || tr_done[5] !== 1'b1 || tr_done[9] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b done: got count=%0d expected 2 at 5 and 9", dones);
        end
    endtask

    task automatic test_fifo_full();
        int dones;
        int guard;
        clear_exp();
        set_exp(2, 41, 4'd1);
        set_exp(46, 49, 4'd2);
        set_exp(54, 57, 4'd3);
        idx = 0;
        drive(1'b1, 4'd1, 16'd10);
        tick_rec();
        drive(1'b1, 4'd0, 16'd1);
        tick_rec();
        drive(1'b1, 4'd2, 16'd1);
        tick_rec();
        drive(1'b1, 4'd0, 16'd1);
        tick_rec();
        drive(1'b1, 4'd3, 16'd1);
        tick_rec();
        tests_run++;
        if (tr_ready[4] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full cmd_ready after fill: got %0b expected 0", tr_ready[4]);
        end
        drive(1'b1, 4'd0, 16'd2);
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            tick_rec();
            guard++;
        end
        tests_run++;
        if (guard >= 100) begin
            tests_failed++;
            $display("[TB] FAIL full wait ready: got timeout expected cmd_ready within 100 cycles");
        end
        tests_run++;
        if (tr_ready[30] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full held off: got cmd_ready=%0b expected 0", tr_ready[30]);
        end
        tick_rec();
        drive(1'b0, 4'd0, 16'd0);
        while (idx <= 70) tick_rec();
        for (int k = 0; k <= 70; k++) begin
            tests_run++;
            if (tr_dir[k] !== exp_dir[k]) begin
                tests_failed++;
                $display("[TB] FAIL full motiondir[%0d]: got %0d expected %0d", k, tr_dir[k], exp_dir[k]);
            end
        end
        dones = 0;
        for (int k = 0; k <= 70; k++) dones += int'(tr_done[k]);
        tests_run++;
        if (dones != 6) begin
            tests_failed++;
            $display("[TB] FAIL full done count: got %0d expected 6", dones);
        end
        tests_run++;
        if (tr_busy[70] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full busy at end: got %0b expected 0", tr_busy[70]);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 4'd7, 16'd5);
        tick();
        drive(1'b0, 4'd0, 16'd0);
        tests_run++;
        if (err_pulse !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL illegal err_pulse: got %0b expected 1", err_pulse);
        end
        tick();
        tests_run++;
        if (err_pulse !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL illegal err width: got %0b expected 0", err_pulse);
        end
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0 || motiondir !== 4'd0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL illegal fifo: got busy=%0b dir=%0d ready=%0b expected 0 0 1", busy, motiondir, cmd_ready);
        end
    endtask

    task automatic test_zero_dur();
        idx = 0;
        drive(1'b1, 4'd4, 16'd0);
        tick_rec();
        drive(1'b0, 4'd0, 16'd0);
        while (idx <= 5) tick_rec();
        tests_run++;
        if (tr_done[0] !== 1'b0 || tr_done[1] !== 1'b1 || tr_done[2] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL zero done: got %0b%0b%0b expected 010", tr_done[0], tr_done[1], tr_done[2]);
        end
        for (int k = 0; k <= 5; k++) begin
            tests_run++;
            if (tr_dir[k] !== 4'd0) begin
                tests_failed++;
                $display("[TB] FAIL zero motiondir[%0d]: got %0d expected 0", k, tr_dir[k]);
            end
        end
    endtask

    task automatic test_abort();
        int bad;
        drive(1'b1, 4'd1, 16'd10);
        tick();
        drive(1'b1, 4'd2, 16'd1);
        tick();
        drive(1'b1, 4'd3, 16'd1);
        tick();
        drive(1'b0, 4'd0, 16'd0);
        repeat (3) tick();
        tests_run++;
        if (motiondir !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL abort pre motiondir: got %0d expected 1", motiondir);
        end
        abort = 1'b1;
        drive(1'b1, 4'd2, 16'd1);
        tick();
        abort = 1'b0;
        drive(1'b0, 4'd0, 16'd0);
        tests_run++;
        if (motiondir !== 4'd0 || busy !== 1'b0 || done_pulse !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort edge: got dir=%0d busy=%0b done=%0b ready=%0b expected 0 0 0 1",
                     motiondir, busy, done_pulse, cmd_ready);
        end
        bad = 0;
        repeat (30) begin
            tick();
            if (motiondir !== 4'd0 || busy !== 1'b0 || done_pulse !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL abort after: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        drive(1'b1, 4'd1, 16'd10);
        tick();
        drive(1'b1, 4'd2, 16'd2);
        tick();
        drive(1'b0, 4'd0, 16'd0);
        repeat (3) tick();
        tests_run++;
        if (motiondir !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid pre motiondir: got %0d expected 1", motiondir);
        end
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (motiondir !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rstmid edge: got dir=%0d busy=%0b ready=%0b expected 0 0 1", motiondir, busy, cmd_ready);
        end
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            tick();
            if (motiondir !== 4'd0 || busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid after: got %0d active cycles expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dir_change();
        test_back_to_back();
        test_fifo_full();
        test_illegal();
        test_zero_dur();
        test_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
